// File: rtl/ltc2324_pkg.sv
// Shared types and constants for the LTC2324 sample controller.
// Optional drop counter is enabled with LTC2324_CTRL_DROP_CNT_EN.
package ltc2324_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StArmed,
      StConverting,
      StDrain
   } state_e;

   localparam int unsigned MIN_PERIOD     = 64;
   localparam int unsigned TIMEOUT_CYCLES = 255;
   localparam int unsigned AXIS_DATA_W    = 64;

   function automatic logic [15:0] max16(input logic [15:0] a, input logic [15:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ltc2324_ctrl_fifo.sv
// Two-entry first-word-fall-through FIFO; a push into a full FIFO is accepted
// when a pop happens on the same edge.
module ltc2324_ctrl_fifo #(
   parameter int unsigned WIDTH = 65
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_q == 2'd2);
   assign empty   = (count_q == 2'd0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign rdata   = mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_ok) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

endmodule

// File: rtl/ltc2324_sample_ctrl.sv
// Periodic start/collect controller for the LTC2324 core with an AXIS output.
// Define LTC2324_CTRL_DROP_CNT_EN to add the saturating drop_cnt output.
module ltc2324_sample_ctrl
   import ltc2324_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [15:0]            period,
   input  logic [15:0]            burst_len,
   output logic                   core_start,
   input  logic                   core_valid,
   input  logic [15:0]            core_ch1,
   input  logic [15:0]            core_ch2,
   input  logic [15:0]            core_ch3,
   input  logic [15:0]            core_ch4,
   output logic [AXIS_DATA_W-1:0] m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tlast,
   output logic                   overrun,
   output logic                   timeout,
   output logic                   busy
`ifdef LTC2324_CTRL_DROP_CNT_EN
   ,
   output logic [15:0]            drop_cnt
`endif
);

   state_e      state_q, state_d;
   logic [15:0] eff_period_q, eff_period_d;
   logic [15:0] eff_burst_q, eff_burst_d;
   logic [15:0] per_cnt_q, per_cnt_d;
   logic [15:0] beat_q, beat_d;
   logic [7:0]  conv_cnt_q, conv_cnt_d;
   logic        overrun_q, overrun_d;
   logic        timeout_q, timeout_d;

   logic        tick, conv_timeout, last_beat;
   logic        result_take, clr_flags, push, pop, can_push;
   logic [1:0]  ovr_events;
   logic        fifo_full, fifo_empty;
   logic [AXIS_DATA_W:0] fifo_rdata;

   assign tick         = (per_cnt_q == eff_period_q - 16'd1);
   assign conv_timeout = (conv_cnt_q == 8'(TIMEOUT_CYCLES - 1));
   assign last_beat    = (beat_q == eff_burst_q - 16'd1);
   assign pop          = m_axis_tvalid && m_axis_tready;
   assign can_push     = !fifo_full || pop;

   always_comb begin
      state_d      = state_q;
      eff_period_d = eff_period_q;
      eff_burst_d  = eff_burst_q;
      per_cnt_d    = per_cnt_q;
      beat_d       = beat_q;
      conv_cnt_d   = conv_cnt_q;
      overrun_d    = overrun_q;
      timeout_d    = timeout_q;
      core_start   = 1'b0;
      result_take  = 1'b0;
      clr_flags    = 1'b0;
      push         = 1'b0;
      ovr_events   = 2'd0;

      if (state_q == StArmed || state_q == StConverting) begin
         per_cnt_d = tick ? 16'd0 : per_cnt_q + 16'd1;
      end
      if (state_q == StConverting || state_q == StDrain) begin
         conv_cnt_d = conv_cnt_q + 8'd1;
      end

      unique case (state_q)
         StIdle: begin
            if (enable) begin
               state_d      = StArmed;
               eff_period_d = max16(period, 16'(MIN_PERIOD));
               eff_burst_d  = max16(burst_len, 16'd1);
               per_cnt_d    = 16'd0;
               beat_d       = 16'd0;
               overrun_d    = 1'b0;
               timeout_d    = 1'b0;
               clr_flags    = 1'b1;
            end
         end
         StArmed: begin
            if (!enable) begin
               state_d = StIdle;
            end else if (tick) begin
               if (fifo_full) begin
                  ovr_events = ovr_events + 2'd1;
               end else begin
                  core_start = 1'b1;
                  state_d    = StConverting;
                  // Counts cycles since the start so the timeout lands
                  // TIMEOUT_CYCLES after the pulse.
                  conv_cnt_d = 8'd1;
               end
            end
         end
         StConverting: begin
            if (tick) begin
               ovr_events = ovr_events + 2'd1;
            end
            if (core_valid) begin
               result_take = 1'b1;
               state_d     = enable ? StArmed : StDrain;
            end else if (conv_timeout) begin
               timeout_d = 1'b1;
               state_d   = enable ? StArmed : StIdle;
            end else if (!enable) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (core_valid) begin
               result_take = 1'b1;
               state_d     = StIdle;
            end else if (conv_timeout) begin
               timeout_d = 1'b1;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (result_take) begin
         if (can_push) begin
            push   = 1'b1;
            beat_d = last_beat ? 16'd0 : beat_q + 16'd1;
         end else begin
            ovr_events = ovr_events + 2'd1;
         end
      end
      if (ovr_events != 2'd0) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         eff_period_q <= 16'd0;
         eff_burst_q  <= 16'd0;
         per_cnt_q    <= 16'd0;
         beat_q       <= 16'd0;
         conv_cnt_q   <= 8'd0;
         overrun_q    <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         eff_period_q <= eff_period_d;
         eff_burst_q  <= eff_burst_d;
         per_cnt_q    <= per_cnt_d;
         beat_q       <= beat_d;
         conv_cnt_q   <= conv_cnt_d;
         overrun_q    <= overrun_d;
         timeout_q    <= timeout_d;
      end
   end

`ifdef LTC2324_CTRL_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic [16:0] drop_sum;

   always_comb begin
      drop_sum   = {1'b0, drop_cnt_q} + {15'd0, ovr_events};
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (clr_flags) begin
         drop_cnt_d = 16'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_q <= 16'd0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`endif

   ltc2324_ctrl_fifo #(
      .WIDTH (AXIS_DATA_W + 1)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata ({last_beat, core_ch4, core_ch3, core_ch2, core_ch1}),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign m_axis_tvalid = !fifo_empty;
   assign m_axis_tdata  = fifo_rdata[AXIS_DATA_W-1:0];
   assign m_axis_tlast  = fifo_rdata[AXIS_DATA_W] && !fifo_empty;
   assign overrun       = overrun_q;
   assign timeout       = timeout_q;
   assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_ltc2324_sample_ctrl.sv
// Directed bench for ltc2324_sample_ctrl with a simple delayed-answer core model.
module tb_ltc2324_sample_ctrl;
   import ltc2324_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] period = 16'd100;
   logic [15:0] burst_len = 16'd4;
   logic        core_start;
   logic        core_valid = 1'b0;
   logic [15:0] core_ch1 = 16'd0, core_ch2 = 16'd0, core_ch3 = 16'd0, core_ch4 = 16'd0;
   logic [63:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic        m_axis_tlast;
   logic        overrun, timeout, busy;
`ifdef LTC2324_CTRL_DROP_CNT_EN
   logic [15:0] drop_cnt;
`endif

   ltc2324_sample_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .period        (period),
      .burst_len     (burst_len),
      .core_start    (core_start),
      .core_valid    (core_valid),
      .core_ch1      (core_ch1),
      .core_ch2      (core_ch2),
      .core_ch3      (core_ch3),
      .core_ch4      (core_ch4),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .overrun       (overrun),
      .timeout       (timeout),
      .busy          (busy)
`ifdef LTC2324_CTRL_DROP_CNT_EN
      ,
      .drop_cnt      (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Core model: answers resp_delay cycles after a start; 0 means never answer.
   int resp_delay = 60;
   int cd = -1;
   int seq = 0;
   always @(negedge clk) begin
      core_valid = 1'b0;
      if (cd > 0) begin
         cd = cd - 1;
         if (cd == 0) begin
            core_valid = 1'b1;
            core_ch1 = 16'h1000 + 16'(seq);
            core_ch2 = 16'h2000 + 16'(seq);
            core_ch3 = 16'h3000 + 16'(seq);
            core_ch4 = 16'h4000 + 16'(seq);
            seq = seq + 1;
            cd = -1;
         end
      end
      if (core_start && resp_delay > 0) cd = resp_delay;
   end

   int          start_q[$];
   logic [64:0] beats_q[$];
   always @(negedge clk) begin
      if (core_start) start_q.push_back(cyc);
      if (m_axis_tvalid && m_axis_tready) beats_q.push_back({m_axis_tlast, m_axis_tdata});
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] exp_data(input int n);
      return {16'h4000 + 16'(n), 16'h3000 + 16'(n), 16'h2000 + 16'(n), 16'h1000 + 16'(n)};
   endfunction

   task automatic tick_to(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_starts(input int n, input int budget);
      int lim;
      lim = cyc + budget;
      while (start_q.size() < n && cyc < lim) begin
         @(posedge clk);
         #1;
      end
      check_eq("start_seen", 64'(start_q.size() >= n), 64'd1);
   endtask

   task automatic do_reset();
      enable = 1'b0;
      rst_n  = 1'b0;
      cd     = -1;
      repeat (3) @(posedge clk);
      #1;
      start_q.delete();
      beats_q.delete();
      seq   = 0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   int en_cyc;
   task automatic arm(input logic [15:0] p, input logic [15:0] b);
      period    = p;
      burst_len = b;
      enable    = 1'b1;
      en_cyc    = cyc;
   endtask

   int s0, s1;

   initial begin
      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check_eq("rst_tlast", 64'(m_axis_tlast), 64'd0);
      check_eq("rst_tdata", m_axis_tdata, 64'd0);
      check_eq("rst_overrun", 64'(overrun), 64'd0);
      check_eq("rst_timeout", 64'(timeout), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_start", 64'(core_start), 64'd0);

      // Normal periodic run, period 100, bursts of 4
      do_reset();
      resp_delay    = 60;
      m_axis_tready = 1'b1;
      arm(16'd100, 16'd4);
      tick_to(en_cyc + 570);
      check_eq("t1_first_start", 64'(start_q[0] - en_cyc), 64'd100);
      for (int i = 1; i < 5; i++) begin
         check_eq("t1_start_gap", 64'(start_q[i] - start_q[i-1]), 64'd100);
      end
      check_eq("t1_nbeats", 64'(beats_q.size()), 64'd5);
      for (int i = 0; i < 5; i++) begin
         check_eq("t1_tlast", 64'(beats_q[i][64]), 64'((i % 4) == 3));
         check_eq("t1_data", beats_q[i][63:0], exp_data(i));
      end
      check_eq("t1_overrun", 64'(overrun), 64'd0);
      check_eq("t1_timeout", 64'(timeout), 64'd0);
      check_eq("t1_busy", 64'(busy), 64'd1);

      // Period below minimum is raised to 64; burst 1 marks every beat last
      do_reset();
      resp_delay = 20;
      arm(16'd10, 16'd1);
      wait_starts(3, 300);
      check_eq("t2_first_start", 64'(start_q[0] - en_cyc), 64'd64);
      check_eq("t2_gap1", 64'(start_q[1] - start_q[0]), 64'd64);
      check_eq("t2_gap2", 64'(start_q[2] - start_q[1]), 64'd64);
      check_eq("t2_tlast0", 64'(beats_q[0][64]), 64'd1);
      check_eq("t2_tlast1", 64'(beats_q[1][64]), 64'd1);

      // Downstream stalled: two beats buffer, third tick overruns
      do_reset();
      resp_delay    = 60;
      m_axis_tready = 1'b0;
      arm(16'd100, 16'd4);
      tick_to(en_cyc + 290);
      check_eq("t3_overrun_pre", 64'(overrun), 64'd0);
      check_eq("t3_tvalid", 64'(m_axis_tvalid), 64'd1);
      check_eq("t3_starts_pre", 64'(start_q.size()), 64'd2);
      tick_to(en_cyc + 305);
      check_eq("t3_overrun", 64'(overrun), 64'd1);
      check_eq("t3_busy", 64'(busy), 64'd1);
      tick_to(en_cyc + 480);
      check_eq("t3_starts", 64'(start_q.size()), 64'd2);
      check_eq("t3_nbeats_stalled", 64'(beats_q.size()), 64'd0);
      m_axis_tready = 1'b1;
      tick_to(en_cyc + 484);
      check_eq("t3_nbeats", 64'(beats_q.size()), 64'd2);
      check_eq("t3_data0", beats_q[0][63:0], exp_data(0));
      check_eq("t3_data1", beats_q[1][63:0], exp_data(1));
      check_eq("t3_tvalid_drained", 64'(m_axis_tvalid), 64'd0);

      // Core never answers: timeout 255 cycles after the start
      do_reset();
      resp_delay = 0;
      arm(16'd100, 16'd4);
      wait_starts(1, 200);
      s0 = start_q[0];
      tick_to(s0 + 254);
      check_eq("t4_timeout_pre", 64'(timeout), 64'd0);
      tick_to(s0 + 255);
      check_eq("t4_timeout", 64'(timeout), 64'd1);
      check_eq("t4_state", 64'(dut.state_q), 64'(StArmed));
      check_eq("t4_overrun", 64'(overrun), 64'd1);
      wait_starts(2, 200);
      check_eq("t4_next_start", 64'(start_q[1] - s0), 64'd300);
      check_eq("t4_nbeats", 64'(beats_q.size()), 64'd0);

      // enable dropped mid-conversion: drain the pending result, then idle
      do_reset();
      resp_delay = 60;
      arm(16'd100, 16'd4);
      wait_starts(1, 200);
      s0 = start_q[0];
      tick_to(s0 + 10);
      enable = 1'b0;
      tick_to(s0 + 12);
      check_eq("t5_state_drain", 64'(dut.state_q), 64'(StDrain));
      check_eq("t5_busy_drain", 64'(busy), 64'd1);
      tick_to(s0 + 62);
      check_eq("t5_busy_idle", 64'(busy), 64'd0);
      check_eq("t5_nbeats", 64'(beats_q.size()), 64'd1);
      check_eq("t5_data", beats_q[0][63:0], exp_data(0));
      check_eq("t5_tlast", 64'(beats_q[0][64]), 64'd0);
      check_eq("t5_nstarts", 64'(start_q.size()), 64'd1);

      // Reset during a conversion with one beat buffered
      do_reset();
      resp_delay    = 60;
      m_axis_tready = 1'b0;
      arm(16'd100, 16'd4);
      wait_starts(2, 300);
      s1 = start_q[1];
      tick_to(s1 + 10);
      check_eq("t6_tvalid_pre", 64'(m_axis_tvalid), 64'd1);
      check_eq("t6_state_conv", 64'(dut.state_q), 64'(StConverting));
      rst_n  = 1'b0;
      enable = 1'b0;
      #1;
      check_eq("t6_tvalid_rst", 64'(m_axis_tvalid), 64'd0);
      check_eq("t6_busy_rst", 64'(busy), 64'd0);
      check_eq("t6_tdata_rst", m_axis_tdata, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      beats_q.delete();
      m_axis_tready = 1'b1;
      tick_to(s1 + 80);
      check_eq("t6_nbeats", 64'(beats_q.size()), 64'd0);
      check_eq("t6_tvalid", 64'(m_axis_tvalid), 64'd0);
      check_eq("t6_busy", 64'(busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ltc2324_sample_ctrl.md
LTC2324_SAMPLE_CTRL -- requirements
Module: ltc2324_sample_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; all ports below are synchronous to clk.
REQ-002 Ports, clock and reset first:
- clk  in  1  system clock.
- rst_n  in  1  async active-low reset.
- enable  in  1  level; run periodic sampling.
- period  in  16  sample period in clk cycles.
- burst_len  in  16  beats per AXIS packet.
- core_start  out  1  one-cycle start pulse to the ADC core.
- core_valid  in  1  one-cycle result strobe from the core.
- core_ch1..core_ch4  in  16 each  core results, valid with core_valid.
- m_axis_tdata  out  64  {ch4,ch3,ch2,ch1}.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of packet.
- overrun  out  1  sticky flag; a sample was dropped.
- timeout  out  1  sticky flag; the core did not answer.
- busy  out  1  state != IDLE.

Function
REQ-003 States: IDLE, ARMED (period counting), CONVERTING (start issued, awaiting core_valid), DRAIN (enable low, awaiting the last result).
REQ-004 IDLE->ARMED when enable=1.
- Latches eff_period = max(period, MIN_PERIOD).
- Latches eff_burst = max(burst_len, 1).
- Clears the period counter and the beat counter.
- Changes to period or burst_len while busy are ignored.
REQ-005 In ARMED and CONVERTING the period counter runs continuously; it wraps to 0 on reaching eff_period-1, producing a tick.
REQ-006 Tick in ARMED with FIFO not full: core_start=1 for exactly that cycle; next state CONVERTING.
- First start occurs eff_period cycles after leaving IDLE.
REQ-007 Tick in ARMED with FIFO full: no start; overrun<=1; stay ARMED.
REQ-008 Tick in CONVERTING: no start; overrun<=1.
REQ-009 core_valid in CONVERTING:
- Push {core_ch4,core_ch3,core_ch2,core_ch1} into the FIFO on the same edge, provided the FIFO is not full, or a pop occurs on that same edge.
- Otherwise drop the result and set overrun<=1.
- Next state: ARMED if enable=1, else DRAIN.
REQ-010 Simultaneous core_valid and tick in CONVERTING: push the result; the tick counts as overrun (no start).
REQ-011 Timeout: if core_valid is not seen within TIMEOUT_CYCLES after core_start:
- timeout<=1;
- leave CONVERTING (to ARMED, or to IDLE if enable=0) without a push.
REQ-012 enable=0 in ARMED -> IDLE next cycle. enable=0 in CONVERTING -> DRAIN. DRAIN -> IDLE on core_valid (push rules of REQ-009) or on timeout.
REQ-013 core_valid outside CONVERTING/DRAIN SHALL be ignored.
REQ-014 Output FIFO:
- 2 entries, each 65 bits (data plus tlast).
- First-word latency: m_axis_tvalid rises the cycle after the push.
- tvalid and tdata stay stable until tvalid&&tready.
- The FIFO keeps draining in every state, including IDLE.
REQ-015 tlast:
- The beat counter advances on each push and wraps at eff_burst.
- The pushed entry carries tlast=1 when beat count == eff_burst-1.
- burst_len=1 gives tlast on every beat.
REQ-016 overrun and timeout SHALL clear only on rst_n or on an IDLE->ARMED transition.

Reset
REQ-017 On rst_n=0, asynchronously:
- state=IDLE;
- all counters =0;
- FIFO empty;
- outputs core_start, m_axis_tvalid, m_axis_tlast, overrun, timeout, busy =0;
- m_axis_tdata =0.
REQ-018 Reset mid-conversion SHALL discard the pending result; a core_valid arriving after reset release is ignored (REQ-013).

Configuration
REQ-019 Macro LTC2324_CTRL_DROP_CNT_EN.
- Defined: adds output drop_cnt[15:0], a saturating count (stops at 16'hFFFF) of every event that sets overrun; cleared with overrun.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Structure
REQ-020 Package ltc2324_pkg SHALL hold:
- the state enum;
- MIN_PERIOD=64;
- TIMEOUT_CYCLES=255;
- the AXIS data width 64.
REQ-021 Sub-module ltc2324_ctrl_fifo: 2-deep FWFT FIFO with parameterised width, full/empty outputs, and async active-low reset.

Verification
REQ-022 The bench SHALL cover:
- period=100, burst_len=4, tready=1, core model answers 60 cycles after start: starts 100 cycles apart; tlast on beats 4, 8, ...; overrun=0.
- period=10: effective period 64; consecutive core_start pulses exactly 64 cycles apart.
- tready=0 throughout, period=100: 2 beats buffered, then overrun=1 at the third tick and no further core_start.
- Core model never returns core_valid: timeout=1 exactly 255 cycles after core_start; controller returns to ARMED and issues the next start.
- enable dropped 10 cycles after core_start: state DRAIN; the result is pushed on core_valid; then IDLE, busy=0.
- rst_n asserted during CONVERTING with 1 beat in the FIFO: tvalid=0, busy=0 immediately; a subsequent core_valid produces no beat.
